// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice.
//   - Channel indices into the NBTN-wide button vectors.
//   - Fire-request FSM state encoding.
package btn_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_SHOOT = 4;

    typedef enum logic [1:0] {
        FIRE_IDLE     = 2'd0,
        FIRE_ARMED    = 2'd1,
        FIRE_COOLDOWN = 2'd2
    } fire_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, clean level and
// one-cycle rise/fall pulses.
// Ports:
//   clk, rst    - system clock, async active-high reset
//   raw         - raw button level, asynchronous to clk
//   level       - debounced level
//   rise, fall  - one-clk pulses in the cycle level changes 0->1 / 1->0
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int CW         = $clog2(DEB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Any return to the current level (bounce) restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioning stage: per-channel sync/debounce/edge detect plus a
// frame-rate-limited, auto-repeating fire request for the shoot channel.
// Ports:
//   clk, rst    - system clock, async active-high reset
//   btn_raw     - raw button levels {shoot, down, up, left, right}, 1 = pressed
//   frame_tick  - one-clk pulse per frame; consumes a pending fire request
//   btn_level   - debounced levels
//   btn_rise    - one-clk pulse per channel on debounced 0->1
//   btn_fall    - one-clk pulse per channel on debounced 1->0
//   fire_req    - shot request, high until consumed by frame_tick
//
// Fire FSM states:
//   state         | meaning
//   FIRE_IDLE     | no request pending; waiting for a shoot rise
//   FIRE_ARMED    | fire_req high; next frame_tick spawns a bullet
//   FIRE_COOLDOWN | rate limit; rcnt counts frames until re-arm or idle
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN          = 5,
    parameter int SHOOT_IDX     = BTN_SHOOT,
    parameter int DEB_CYCLES    = 1000000,
    parameter int CW            = $clog2(DEB_CYCLES),
    parameter int REPEAT_FRAMES = 8,
    parameter int RW            = $clog2(REPEAT_FRAMES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            frame_tick,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_rise,
    output logic [NBTN-1:0] btn_fall,
    output logic            fire_req
);

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .CW        (CW)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end

    fire_state_t   state;
    fire_state_t   state_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          shoot_lvl;
    logic          shoot_rise;

    assign shoot_lvl  = btn_level[SHOOT_IDX];
    assign shoot_rise = btn_rise[SHOOT_IDX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FIRE_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            // A frame_tick coinciding with the rise is not a consume: the
            // request has not been visible on fire_req yet.
            FIRE_IDLE: begin
                if (shoot_rise) state_nxt = FIRE_ARMED;
            end
            // Release does not cancel; a tap is always served once armed.
            FIRE_ARMED: begin
                if (frame_tick) begin
                    state_nxt = FIRE_COOLDOWN;
                    rcnt_nxt  = RW'(REPEAT_FRAMES - 1);
                end
            end
            // Rises here are ignored; only the held level decides re-arm.
            FIRE_COOLDOWN: begin
                if (frame_tick) begin
                    if (rcnt == RW'(1)) begin
                        state_nxt = shoot_lvl ? FIRE_ARMED : FIRE_IDLE;
                    end else begin
                        rcnt_nxt = rcnt - RW'(1);
                    end
                end
            end
            default: state_nxt = FIRE_IDLE;
        endcase
    end

    assign fire_req = (state == FIRE_ARMED);

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CYCLES=4, REPEAT_FRAMES=3 and
// frame_tick every 20 clks. Inputs change 1 time unit after each rising edge;
// outputs are sampled at that same point.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic       frame_tick;
    logic [4:0] btn_level;
    logic [4:0] btn_rise;
    logic [4:0] btn_fall;
    logic       fire_req;

    btn_conditioner #(
        .NBTN         (5),
        .SHOOT_IDX    (4),
        .DEB_CYCLES   (4),
        .REPEAT_FRAMES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .frame_tick(frame_tick),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .fire_req  (fire_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic       tick;
        logic [4:0] lvl;
        logic [4:0] rise;
        logic [4:0] fall;
        logic       fire;
    } vec_t;

    vec_t vecs[$];

    int total;
    int bad;
    int ft_en;
    int fcnt;
    int fnum;
    int cons;
    int fire_hi;
    int rise0;
    int fall0;
    int cq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] raw, input logic tick,
                       input logic [4:0] lvl, input logic [4:0] rise,
                       input logic [4:0] fall, input logic fire);
        vec_t v;
        v.rst = r; v.raw = raw; v.tick = tick;
        v.lvl = lvl; v.rise = rise; v.fall = fall; v.fire = fire;
        vecs.push_back(v);
    endtask

    // One rising edge; records handshake and pulse statistics, then advances
    // the frame_tick generator.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            logic pre_cons;
            logic pre_tick;
            pre_cons = fire_req & frame_tick;
            pre_tick = frame_tick;
            @(posedge clk);
            #1;
            if (pre_tick) fnum++;
            if (pre_cons) begin
                cons++;
                cq.push_back(fnum);
            end
            fire_hi += int'(fire_req);
            rise0   += int'(btn_rise[0]);
            fall0   += int'(btn_fall[0]);
            if (ft_en != 0) begin
                fcnt       = (fcnt == 19) ? 0 : fcnt + 1;
                frame_tick = (fcnt == 19);
            end else begin
                frame_tick = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        ft_en      = 0;
        frame_tick = 1'b0;
        btn_raw    = 5'h00;
        rst        = 1'b1;
        cyc(2);
        rst     = 1'b0;
        fcnt    = 0;
        fnum    = 0;
        cons    = 0;
        fire_hi = 0;
        rise0   = 0;
        fall0   = 0;
        cq.delete();
    endtask

    initial begin
        int lat;
        total = 0; bad = 0;
        ft_en = 0; fcnt = 0; fnum = 0; cons = 0; fire_hi = 0; rise0 = 0; fall0 = 0;
        rst = 1'b1; btn_raw = 5'h00; frame_tick = 1'b0;
        #1;

        //   rst raw    tick lvl    rise   fall   fire
        add(1, 5'h1F, 0, 5'h00, 5'h00, 5'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 5'h1F, 0, 5'h00, 5'h00, 5'h00, 0);
        add(0, 5'h1F, 0, 5'h1F, 5'h1F, 5'h00, 0);
        add(0, 5'h1F, 0, 5'h1F, 5'h00, 5'h00, 1);
        add(0, 5'h0A, 1, 5'h1F, 5'h00, 5'h00, 0);
        for (int i = 0; i < 4; i++) add(0, 5'h0A, 0, 5'h1F, 5'h00, 5'h00, 0);
        add(0, 5'h0A, 0, 5'h0A, 5'h00, 5'h15, 0);
        add(0, 5'h0A, 0, 5'h0A, 5'h00, 5'h00, 0);
        add(0, 5'h0A, 1, 5'h0A, 5'h00, 5'h00, 0);
        add(0, 5'h0A, 1, 5'h0A, 5'h00, 5'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 5'h15, 0, 5'h0A, 5'h00, 5'h00, 0);
        add(0, 5'h15, 0, 5'h15, 5'h15, 5'h0A, 0);
        add(0, 5'h15, 1, 5'h15, 5'h00, 5'h00, 1);
        add(0, 5'h15, 1, 5'h15, 5'h00, 5'h00, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            rst        = vecs[r].rst;
            btn_raw    = vecs[r].raw;
            frame_tick = vecs[r].tick;
            cyc(1);
            chk($sformatf("vec%0d_level", r), int'(btn_level), int'(vecs[r].lvl));
            chk($sformatf("vec%0d_rise", r),  int'(btn_rise),  int'(vecs[r].rise));
            chk($sformatf("vec%0d_fall", r),  int'(btn_fall),  int'(vecs[r].fall));
            chk($sformatf("vec%0d_fire", r),  int'(fire_req),  int'(vecs[r].fire));
        end

        // Asynchronous reset mid-run while ARMED with all buttons held.
        do_reset();
        btn_raw = 5'h1F;
        cyc(8);
        chk("pre_rst_fire", int'(fire_req), 1);
        rst = 1'b1;
        #2;
        chk("async_rst_level", int'(btn_level), 0);
        chk("async_rst_rise",  int'(btn_rise),  0);
        chk("async_rst_fall",  int'(btn_fall),  0);
        chk("async_rst_fire",  int'(fire_req),  0);
        cyc(1);
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (btn_level == 5'h1F) begin
                lat = k;
                break;
            end
        end
        chk("rst_release_latency", lat, 6);
        chk("rst_release_rise", int'(btn_rise), 32'h1F);
        cyc(1);
        chk("rst_release_rise_width", int'(btn_rise), 0);

        // Bounce on channel 0.
        do_reset();
        btn_raw = 5'h01; cyc(2);
        btn_raw = 5'h00; cyc(2);
        btn_raw = 5'h01; cyc(2);
        btn_raw = 5'h00; cyc(2);
        btn_raw = 5'h01;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (btn_level[0]) begin
                lat = k;
                break;
            end
        end
        chk("bounce_latency", lat, 6);
        cyc(5);
        chk("bounce_rise_count", rise0, 1);
        chk("bounce_fall_count", fall0, 0);

        // Single tap released before the first frame_tick.
        do_reset();
        ft_en = 1;
        btn_raw = 5'h10; cyc(10);
        btn_raw = 5'h00; cyc(90);
        chk("tap_consumes", cons, 1);
        chk("tap_fire_high_cycles", fire_hi, 13);
        chk("tap_consume_frame", (cq.size() > 0) ? cq[0] : -1, 1);

        // Shoot held for 10 frames: consumes on frames 1, 4, 7, 10.
        do_reset();
        ft_en = 1;
        btn_raw = 5'h10; cyc(200);
        chk("held_consumes", cons, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("held_consume%0d_frame", i),
                (cq.size() > i) ? cq[i] : -1, 1 + 3 * i);
        chk("held_fire_high_cycles", fire_hi, 73);

        // Rate limit: a full press/release inside cooldown is dropped.
        do_reset();
        ft_en = 1;
        btn_raw = 5'h10; cyc(10);
        btn_raw = 5'h00; cyc(30);
        btn_raw = 5'h10; cyc(10);
        btn_raw = 5'h00; cyc(40);
        chk("ratelimit_consumes", cons, 1);
        chk("ratelimit_fire_high_cycles", fire_hi, 13);
        btn_raw = 5'h10; cyc(8);
        chk("ratelimit_rearm_from_idle", int'(fire_req), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
